// File: rtl/data_sram_responder.sv
// Single-cycle data SRAM plus MMIO register window (LED, optional TIMER/COMPARE/STATUS).
// Define RESP_TIMER_EN to build the timer, compare match and timer_irq logic.
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              win_hit;
  logic [ADDR_W-1:0] word_idx;
  logic [15:0]       reg_off;
  logic              rd_req;
  logic              wr_req;
  logic              ram_wr;
  logic              reg_wr;
  logic [31:0]       reg_rdata;
  logic [31:0]       timer_rd;
  logic [31:0]       compare_rd;
  logic              pending_rd;
  logic [15:0]       led_q;
  logic [31:0]       rdata_p1;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  assign win_hit  = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign word_idx = data_sram_addr[ADDR_W+1:2];
  assign reg_off  = data_sram_addr[15:0];
  assign rd_req   = data_sram_en && (data_sram_we == 4'b0000);
  assign wr_req   = data_sram_en && (data_sram_we != 4'b0000);
  assign ram_wr   = wr_req && !win_hit;
  assign reg_wr   = wr_req && win_hit;

  // RAM array carries no reset so its contents survive resetn.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q <= '0;
    end else if (reg_wr && (reg_off == 16'h0008)) begin
      led_q <= {data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8],
                data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0]};
    end
  end

`ifdef RESP_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] compare_q;
  logic        pending_q;
  logic        timer_wr;
  logic        compare_wr;
  logic        status_clr;
  logic        match;

  assign timer_wr   = reg_wr && (reg_off == 16'h0000);
  assign compare_wr = reg_wr && (reg_off == 16'h0004);
  assign status_clr = reg_wr && (reg_off == 16'h000C) && data_sram_we[0] && data_sram_wdata[0];
  assign match      = (timer_q == compare_q);

  // A software write to TIMER replaces that cycle's increment; a match beats a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      pending_q <= 1'b0;
    end else begin
      timer_q <= timer_wr ? lane_merge(timer_q, data_sram_wdata, data_sram_we)
                          : timer_q + 32'd1;
      if (compare_wr) begin
        compare_q <= lane_merge(compare_q, data_sram_wdata, data_sram_we);
      end
      if (match) begin
        pending_q <= 1'b1;
      end else if (status_clr) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign timer_rd   = timer_q;
  assign compare_rd = compare_q;
  assign pending_rd = pending_q;
  assign timer_irq  = pending_q;
`else
  assign timer_rd   = '0;
  assign compare_rd = '0;
  assign pending_rd = 1'b0;
  assign timer_irq  = 1'b0;
`endif

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      16'h0000: reg_rdata = timer_rd;
      16'h0004: reg_rdata = compare_rd;
      16'h0008: reg_rdata = {16'h0000, led_q};
      16'h000C: reg_rdata = {31'd0, pending_rd};
      default:  reg_rdata = '0;
    endcase
  end

  // Read stage boundary: data captured at the request edge, held until the next read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_p1 <= '0;
    end else if (rd_req) begin
      rdata_p1 <= win_hit ? reg_rdata : mem[word_idx];
    end
  end

  assign data_sram_rdata = rdata_p1;
  assign led             = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: vector table plus timer/reset sequences.
module tb_data_sram_responder;

`ifdef RESP_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic        timer_irq;

  int checks;
  int errors;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .timer_irq       (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;

    vecs[0]  = '{1'b1, 4'hF,    32'h0000_0040, 32'h1234_5678, 32'h0000_0000, 16'h0000};
    vecs[1]  = '{1'b1, 4'h0,    32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 16'h0000};
    vecs[2]  = '{1'b1, 4'b0010, 32'h0000_0040, 32'hDEAD_ABEF, 32'h1234_5678, 16'h0000};
    vecs[3]  = '{1'b1, 4'h0,    32'h0000_0040, 32'h0000_0000, 32'h1234_AB78, 16'h0000};
    vecs[4]  = '{1'b0, 4'h0,    32'h0000_0000, 32'h0000_0000, 32'h1234_AB78, 16'h0000};
    vecs[5]  = '{1'b0, 4'hF,    32'h0000_0040, 32'h5555_5555, 32'h1234_AB78, 16'h0000};
    vecs[6]  = '{1'b1, 4'h0,    32'h0000_0040, 32'h0000_0000, 32'h1234_AB78, 16'h0000};
    vecs[7]  = '{1'b1, 4'hF,    32'h0000_1080, 32'hCAFE_F00D, 32'h1234_AB78, 16'h0000};
    vecs[8]  = '{1'b1, 4'h0,    32'h0000_0080, 32'h0000_0000, 32'hCAFE_F00D, 16'h0000};
    vecs[9]  = '{1'b1, 4'hF,    32'hBFAF_0008, 32'hFFFF_A5A5, 32'hCAFE_F00D, 16'hA5A5};
    vecs[10] = '{1'b1, 4'h0,    32'hBFAF_0008, 32'h0000_0000, 32'h0000_A5A5, 16'hA5A5};
    vecs[11] = '{1'b1, 4'h0,    32'hBFAF_0010, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
    vecs[12] = '{1'b1, 4'hF,    32'hBFAF_0010, 32'h1234_5678, 32'h0000_0000, 16'hA5A5};
    vecs[13] = '{1'b1, 4'h0,    32'hBFAF_0010, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
    vecs[14] = '{1'b1, 4'b0010, 32'hBFAF_0008, 32'h0000_3C00, 32'h0000_0000, 16'h3CA5};
    vecs[15] = '{1'b1, 4'h0,    32'hBFAF_0008, 32'h0000_0000, 32'h0000_3CA5, 16'h3CA5};
    vecs[16] = '{1'b1, 4'h0,    32'h0000_0042, 32'h0000_0000, 32'h1234_AB78, 16'h3CA5};
    vecs[17] = '{1'b1, 4'h0,    32'hBFAE_0040, 32'h0000_0000, 32'h1234_AB78, 16'h3CA5};

    #12;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_irq", {31'h0, timer_irq}, 32'h0);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), data_sram_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
      check($sformatf("vec%0d_irq", i), {31'h0, timer_irq}, 32'h0);
    end

    // Compare match: TIMER=0, then COMPARE=20 leaves TIMER at 1.
    step(1'b1, 4'hF, 32'hBFAF_0000, 32'd0);
    step(1'b1, 4'hF, 32'hBFAF_0004, 32'd20);
    for (int j = 1; j <= 19; j++) idle();
    check("irq_before_match", {31'h0, timer_irq}, 32'h0);
    idle();
    check("irq_at_match", {31'h0, timer_irq}, {31'h0, TEN});
    step(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
    check("status_read", data_sram_rdata, {31'h0, TEN});
    step(1'b1, 4'h1, 32'hBFAF_000C, 32'h1);
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);

    // Clear lands on the same edge as a match: set must win.
    step(1'b1, 4'hF, 32'hBFAF_0000, 32'd50);
    step(1'b1, 4'hF, 32'hBFAF_0004, 32'd52);
    idle();
    check("irq_pre_coincide", {31'h0, timer_irq}, 32'h0);
    step(1'b1, 4'h1, 32'hBFAF_000C, 32'h1);
    check("irq_set_wins", {31'h0, timer_irq}, {31'h0, TEN});
    step(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    check("compare_read", data_sram_rdata, TEN ? 32'd52 : 32'd0);

    // Wrap: TIMER=FFFF_FFFE, read sees the pre-edge value.
    step(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFE);
    idle();
    step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_max", data_sram_rdata, TEN ? 32'hFFFF_FFFF : 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);
    check("irq_before_reset", {31'h0, timer_irq}, {31'h0, TEN});

    // Reset asserted while a read request is pending.
    data_sram_en   = 1'b1;
    data_sram_we   = 4'h0;
    data_sram_addr = 32'h0000_0040;
    #2 resetn = 1'b0;
    #1;
    check("midread_rdata", data_sram_rdata, 32'h0);
    check("midread_led", {16'h0, led}, 32'h0);
    check("midread_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    check("held_rdata", data_sram_rdata, 32'h0);
    resetn = 1'b1;
    step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_after_reset", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    check("ram_kept_40", data_sram_rdata, 32'h1234_AB78);
    step(1'b1, 4'h0, 32'h0000_0080, 32'h0);
    check("ram_kept_80", data_sram_rdata, 32'hCAFE_F00D);
    step(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
    check("timer_counting", data_sram_rdata, TEN ? 32'd3 : 32'd0);
    step(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    check("compare_reset", data_sram_rdata, TEN ? 32'hFFFF_FFFF : 32'h0);
    check("led_after_reset", {16'h0, led}, 32'h0);
    check("irq_after_reset", {31'h0, timer_irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
